// File: rtl/image_rom_arb_pkg.sv
// rtl/image_rom_arb_pkg.sv - shared FSM state type and default widths for the image ROM arbiter
package image_rom_arb_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 12;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/image_rom_arbiter_rr_pick.sv
// rtl/image_rom_arbiter_rr_pick.sv - combinational round-robin winner selection (module rr_pick)
module rr_pick
    import image_rom_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] winner
);

    logic [IDX_W-1:0] idx;

    // Walk the ring starting just after the last owner; the first active request wins.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/image_rom_arbiter.sv
// rtl/image_rom_arbiter.sv - round-robin burst arbiter for a shared image ROM; optional IMAGE_ROM_ARB_TRANSP_EN
module image_rom_arbiter
    import image_rom_arb_pkg::*;
#(
    parameter int                N_REQ      = 2,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                MAX_BURST  = 8,
    parameter logic [DATA_W-1:0] TRANSP_KEY = DATA_W'(12'hF0F)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_rgb,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rgb
`ifdef IMAGE_ROM_ARB_TRANSP_EN
    ,
    output logic                    rsp_transp
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = 8;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              p1_valid_q, p1_valid_d;
    logic [IDX_W-1:0]  p1_idx_q, p1_idx_d;
    logic              p2_valid_q, p2_valid_d;
    logic [IDX_W-1:0]  p2_idx_q, p2_idx_d;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              xfer;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_idx)
    );

    assign xfer = (state_q == GRANT) && req[owner_q];

    // Burst FSM: pick a winner in IDLE, count transfers in GRANT, hand the pointer on at exit.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
                    state_d = IDLE;
                    ptr_d   = owner_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ROM address capture and two-stage response tracking (address stage, ROM read stage).
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (xfer) begin
            rom_addr_d = addr_in[int'(owner_q)*ADDR_W +: ADDR_W];
        end
        p1_valid_d = xfer;
        p1_idx_d   = owner_q;
        p2_valid_d = p1_valid_q;
        p2_idx_d   = p1_idx_q;
    end

    // Grant follows the owner's request so a dropped request cancels the transfer immediately.
    always_comb begin
        gnt = '0;
        if (state_q == GRANT) begin
            gnt[owner_q] = req[owner_q];
        end
    end

    // Response strobe is routed to the requester that issued the read two cycles earlier.
    always_comb begin
        rsp_valid = '0;
        if (p2_valid_q) begin
            rsp_valid[p2_idx_q] = 1'b1;
        end
    end

    assign rom_addr = rom_addr_q;
    assign rsp_rgb  = rom_rgb;

`ifdef IMAGE_ROM_ARB_TRANSP_EN
    assign rsp_transp = p2_valid_q && (rom_rgb == TRANSP_KEY);
`else
    localparam logic [DATA_W-1:0] unused_transp_key = TRANSP_KEY;
`endif

    // State registers; reset parks ptr on the last requester so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= IDX_W'(N_REQ - 1);
            cnt_q      <= '0;
            rom_addr_q <= '0;
            p1_valid_q <= 1'b0;
            p1_idx_q   <= '0;
            p2_valid_q <= 1'b0;
            p2_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            p1_valid_q <= p1_valid_d;
            p1_idx_q   <= p1_idx_d;
            p2_valid_q <= p2_valid_d;
            p2_idx_q   <= p2_idx_d;
        end
    end

endmodule

// File: tb/tb_image_rom_arbiter.sv
// tb/tb_image_rom_arbiter.sv - self-checking bench for image_rom_arbiter; optional IMAGE_ROM_ARB_TRANSP_EN
module tb_image_rom_arbiter;

    localparam int N    = 2;
    localparam int AW   = 14;
    localparam int DW   = 12;
    localparam int MAXB = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] addr_in;
    logic [N-1:0]    gnt;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_rgb;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rgb;
`ifdef IMAGE_ROM_ARB_TRANSP_EN
    logic            rsp_transp;
`endif

    logic [DW-1:0] rom [0:(1<<AW)-1];

    image_rom_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .addr_in   (addr_in),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_rgb   (rom_rgb),
        .rsp_valid (rsp_valid),
        .rsp_rgb   (rsp_rgb)
`ifdef IMAGE_ROM_ARB_TRANSP_EN
        ,
        .rsp_transp(rsp_transp)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rgb <= rom[rom_addr];

    typedef struct {
        int            due;
        int            idx;
        logic [AW-1:0] addr;
    } rsp_t;

    rsp_t          rq[$];
    bit            m_grant;
    int            m_owner;
    int            m_ptr;
    int            m_cnt;
    int            cyc;
    logic [AW-1:0] m_addr;
    int            n_x0;
    int            n_x1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit req_of(input logic [N-1:0] r, input int i);
        return (i == 0) ? r[0] : r[1];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return (i == 0) ? 2'b01 : 2'b10;
    endfunction

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic [N-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rv;
        logic [DW-1:0] e_rgb;
        logic [AW-1:0] a_own;
        int            first;
        rsp_t          ent;
        @(negedge clk);
        req     = r;
        addr_in = {a1, a0};
        #1;
        e_gnt = '0;
        if (m_grant && req_of(r, m_owner)) e_gnt = onehot(m_owner);
        e_rv  = '0;
        e_rgb = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_rv  = onehot(rq[0].idx);
            e_rgb = rom[rq[0].addr];
            void'(rq.pop_front());
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        if (e_rv != '0) chk("rsp_rgb", 32'(rsp_rgb), 32'(e_rgb));
        chk("rom_addr", 32'(rom_addr), 32'(m_addr));
`ifdef IMAGE_ROM_ARB_TRANSP_EN
        chk("rsp_transp", 32'(rsp_transp), 32'((e_rv != '0) && (e_rgb == 12'hF0F)));
`endif
        if (!m_grant) begin
            if (r != '0) begin
                first   = (m_ptr + 1) % N;
                m_owner = req_of(r, first) ? first : (first + 1) % N;
                m_grant = 1'b1;
            end
        end else if (!req_of(r, m_owner)) begin
            m_grant = 1'b0;
            m_ptr   = m_owner;
            m_cnt   = 0;
        end else begin
            a_own    = (m_owner == 0) ? a0 : a1;
            ent.due  = cyc + 2;
            ent.idx  = m_owner;
            ent.addr = a_own;
            rq.push_back(ent);
            m_addr = a_own;
            if (m_owner == 0) n_x0++;
            else n_x1++;
            m_cnt++;
            if (m_cnt == MAXB) begin
                m_grant = 1'b0;
                m_ptr   = m_owner;
                m_cnt   = 0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        #1;
        m_grant = 1'b0;
        m_owner = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
        m_addr  = '0;
        rq.delete();
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(0));
`ifdef IMAGE_ROM_ARB_TRANSP_EN
        chk("rst_rsp_transp", 32'(rsp_transp), 32'(0));
`endif
        @(negedge clk);
        #1;
        chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_hold_gnt", 32'(gnt), 32'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        int c0;
        int c1;
        int run;
        int maxrun;
        int cz;
        int ct;
        int x1b;
        int k;

        rst_n   = 1'b0;
        req     = '0;
        addr_in = '0;
        cyc     = 0;
        n_x0    = 0;
        n_x1    = 0;
        for (int i = 0; i < (1 << AW); i++) rom[i] = DW'($urandom);
        rom[100] = 12'hF0F;
        rom[101] = 12'hF0E;

        do_reset();

        // Both request after reset; requester 0 bursts 8 from 0..7, then requester 1 drops after 3.
        c0 = 0; c1 = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 22; i++) begin
            step({n_x1 < 3, n_x0 < 8}, AW'(n_x0), AW'(200 + n_x1));
            if (i == 0) chk("r033_gnt_cycle1", 32'(gnt), 32'(0));
            if (i == 1) chk("r033_gnt_cycle2", 32'(gnt), 32'(2'b01));
            if (rsp_valid[0]) begin
                c0++;
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            if (rsp_valid[1]) c1++;
        end
        chk("r034_rsp0_count", 32'(c0), 32'(8));
        chk("r034_rsp0_run", 32'(maxrun), 32'(8));
        chk("r035_rsp1_count", 32'(c1), 32'(3));

        // ptr now sits on requester 1, so requester 0 wins the next contest.
        step(2'b00, '0, '0);
        step(2'b11, AW'(300), AW'(301));
        step(2'b11, AW'(302), AW'(303));
        chk("r035_ptr_next_winner", 32'(gnt), 32'(2'b01));

        // Reset lands one cycle after that transfer; its response must never appear.
        do_reset();
        cz = 0;
        for (int i = 0; i < 4; i++) begin
            step(2'b00, '0, '0);
            if (rsp_valid != '0) cz++;
        end
        chk("r036_no_rsp_after_reset", 32'(cz), 32'(0));
        chk("r036_rom_addr", 32'(rom_addr), 32'(0));

        // Requester 1 reads the transparent key word then its neighbour.
        x1b = n_x1;
        ct  = 0;
        for (int i = 0; i < 8; i++) begin
            k = n_x1 - x1b;
            step({k < 2, 1'b0}, '0, AW'(100 + k));
`ifdef IMAGE_ROM_ARB_TRANSP_EN
            if (rsp_transp) ct++;
`endif
        end
`ifdef IMAGE_ROM_ARB_TRANSP_EN
        chk("r037_transp_count", 32'(ct), 32'(1));
`endif

        // Random traffic with one mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(N'($urandom_range(0, 3)), AW'($urandom), AW'($urandom));
        end
        for (int i = 0; i < 3; i++) step(2'b00, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
